// File: rtl/raster_pkg.sv
// Shared types and defaults for the FAST candidate raster scanner.
package raster_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } scan_state_t;

  localparam int unsigned DEFAULT_BORDER = 3;

endpackage

// File: rtl/scan_axis_counter.sv
// One coordinate axis: loadable up/down index counter with terminal detect.
module scan_axis_counter #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         dir,
  input  logic [W-1:0] max_val,
  input  logic [W-1:0] min_val,
  output logic [W-1:0] value,
  output logic         at_end
);

  logic [W-1:0] value_q;

  // Load has priority over step; dir=1 counts down.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_val;
    end else if (step) begin
      value_q <= dir ? (value_q - W'(1)) : (value_q + W'(1));
    end
  end

  assign value  = value_q;
  assign at_end = dir ? (value_q == min_val) : (value_q == max_val);

endmodule

// File: rtl/raster_scan_ctrl.sv
// Raster scan front-end for the FAST detector: walks the image interior
// (BORDER margin excluded) and hands out one (x,y) per valid/ready handshake.
// Build option: define SERPENTINE_EN to reverse x direction on odd rows.
module raster_scan_ctrl
  import raster_pkg::*;
#(
  parameter int unsigned X_W    = 10,
  parameter int unsigned Y_W    = 10,
  parameter int unsigned BORDER = DEFAULT_BORDER
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           start,
  input  logic           abort,
  input  logic [X_W-1:0] img_width,
  input  logic [Y_W-1:0] img_height,
  input  logic           coord_ready,
  output logic           coord_valid,
  output logic [X_W-1:0] coord_x,
  output logic [Y_W-1:0] coord_y,
  output logic           row_start,
  output logic           last,
  output logic           busy,
  output logic           done,
  output logic           cfg_err
);

  localparam int unsigned MIN_DIM = 2 * BORDER + 1;
  localparam logic [X_W-1:0] X_MIN = X_W'(BORDER);
  localparam logic [Y_W-1:0] Y_MIN = Y_W'(BORDER);

  scan_state_t    state_q, state_d;
  logic [X_W-1:0] w_q, w_d, x_max_q, x_max_d;
  logic [Y_W-1:0] h_q, h_d, y_max_q, y_max_d;
  logic           dir_q, dir_d;
  logic           cfg_err_q, cfg_err_d;
  logic           valid_q, busy_q, done_q;

  logic [X_W-1:0] x_val;
  logic [Y_W-1:0] y_val;
  logic           x_at_end, y_at_end, x_at_start;
  logic           x_load, x_step, y_load, y_step;
  logic           hs, last_c, too_small;

  scan_axis_counter #(.W(X_W)) u_x_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (x_load),
    .load_val (X_MIN),
    .step     (x_step),
    .dir      (dir_q),
    .max_val  (x_max_q),
    .min_val  (X_MIN),
    .value    (x_val),
    .at_end   (x_at_end)
  );

  scan_axis_counter #(.W(Y_W)) u_y_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (y_load),
    .load_val (Y_MIN),
    .step     (y_step),
    .dir      (1'b0),
    .max_val  (y_max_q),
    .min_val  (Y_MIN),
    .value    (y_val),
    .at_end   (y_at_end)
  );

  assign hs         = valid_q && coord_ready;
  assign last_c     = x_at_end && y_at_end;
  assign x_at_start = dir_q ? (x_val == x_max_q) : (x_val == X_MIN);
  assign too_small  = (w_q < X_W'(MIN_DIM)) || (h_q < Y_W'(MIN_DIM));

  // Next-state and counter control; abort overrides everything at the end.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    x_max_d   = x_max_q;
    y_max_d   = y_max_q;
    dir_d     = dir_q;
    cfg_err_d = cfg_err_q;
    x_load    = 1'b0;
    x_step    = 1'b0;
    y_load    = 1'b0;
    y_step    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          w_d       = img_width;
          h_d       = img_height;
          cfg_err_d = 1'b0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        x_max_d = w_q - X_W'(BORDER + 1);
        y_max_d = h_q - Y_W'(BORDER + 1);
        x_load  = 1'b1;
        y_load  = 1'b1;
        dir_d   = 1'b0;
        if (too_small) begin
          cfg_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hs) begin
          if (last_c) begin
            state_d = DONE;
          end else if (x_at_end) begin
            y_step = 1'b1;
`ifdef SERPENTINE_EN
            dir_d  = ~dir_q;
`else
            x_load = 1'b1;
`endif
          end else begin
            x_step = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q == LOAD || state_q == SCAN)) begin
      state_d   = IDLE;
      cfg_err_d = cfg_err_q;
      x_load    = 1'b0;
      x_step    = 1'b0;
      y_load    = 1'b0;
      y_step    = 1'b0;
    end
  end

  // State, latched configuration and registered status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      x_max_q   <= '0;
      y_max_q   <= '0;
      dir_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      x_max_q   <= x_max_d;
      y_max_q   <= y_max_d;
      dir_q     <= dir_d;
      cfg_err_q <= cfg_err_d;
      valid_q   <= (state_d == SCAN);
      busy_q    <= (state_d == LOAD) || (state_d == SCAN);
      done_q    <= (state_d == DONE);
    end
  end

  assign coord_valid = valid_q;
  assign coord_x     = x_val;
  assign coord_y     = y_val;
  assign row_start   = valid_q && x_at_start;
  assign last        = valid_q && last_c;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Directed bench for raster_scan_ctrl using a 10x9 image (12 interior pixels).
// With SERPENTINE_EN defined the expected order reverses x on odd rows.
module tb_raster_scan_ctrl;

  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 10;

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           coord_ready = 1'b0;
  logic [X_W-1:0] img_width = '0;
  logic [Y_W-1:0] img_height = '0;
  logic           coord_valid, row_start, last, busy, done, cfg_err;
  logic [X_W-1:0] coord_x;
  logic [Y_W-1:0] coord_y;

  int checks = 0;
  int errors = 0;
  int exp_x[12];
  int exp_y[12];

  logic [22:0] obs_coord;
  logic [3:0]  obs_ctl;

  raster_scan_ctrl #(.X_W(X_W), .Y_W(Y_W), .BORDER(3)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .abort       (abort),
    .img_width   (img_width),
    .img_height  (img_height),
    .coord_ready (coord_ready),
    .coord_valid (coord_valid),
    .coord_x     (coord_x),
    .coord_y     (coord_y),
    .row_start   (row_start),
    .last        (last),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  assign obs_coord = {coord_valid, row_start, last, coord_x, coord_y};
  assign obs_ctl   = {busy, done, cfg_err, coord_valid};

  // Expected {valid,row_start,last,x,y} for the i-th coordinate of the 10x9 scan.
  function automatic logic [22:0] exp_coord(input int i);
    return {1'b1, (i % 4 == 0), (i == 11), X_W'(exp_x[i]), Y_W'(exp_y[i])};
  endfunction

  // Drive start for one cycle (or keep it high); returns at the LOAD-cycle negedge.
  task automatic begin_scan(input int w, input int h, input bit keep);
    img_width  = X_W'(w);
    img_height = Y_W'(h);
    start      = 1'b1;
    @(negedge clk);
    if (!keep) start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (obs_ctl !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected 0000", obs_ctl);
    end
    checks++;
    if (obs_coord !== 23'd0) begin
      errors++;
      $display("FAIL reset_coord: got %h expected 0", obs_coord);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_raster();
    coord_ready = 1'b1;
    begin_scan(10, 9, 1'b0);
    checks++;
    if (obs_ctl !== 4'b1000) begin
      errors++;
      $display("FAIL raster_load: got %b expected 1000", obs_ctl);
    end
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (obs_coord !== exp_coord(i)) begin
        errors++;
        $display("FAIL raster_coord%0d: got %h expected %h", i, obs_coord, exp_coord(i));
      end
      @(negedge clk);
    end
    checks++;
    if (obs_ctl !== 4'b0100) begin
      errors++;
      $display("FAIL raster_done: got %b expected 0100", obs_ctl);
    end
    @(negedge clk);
    checks++;
    if (obs_ctl !== 4'b0000) begin
      errors++;
      $display("FAIL raster_idle: got %b expected 0000", obs_ctl);
    end
  endtask

  task automatic test_backpressure();
    coord_ready = 1'b1;
    begin_scan(10, 9, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 6; i++) @(negedge clk);
    checks++;
    if (obs_coord !== exp_coord(6)) begin
      errors++;
      $display("FAIL bp_present: got %h expected %h", obs_coord, exp_coord(6));
    end
    coord_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (obs_coord !== exp_coord(6)) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h expected %h", k, obs_coord, exp_coord(6));
      end
    end
    coord_ready = 1'b1;
    @(negedge clk);
    for (int i = 7; i < 12; i++) begin
      checks++;
      if (obs_coord !== exp_coord(i)) begin
        errors++;
        $display("FAIL bp_coord%0d: got %h expected %h", i, obs_coord, exp_coord(i));
      end
      @(negedge clk);
    end
    checks++;
    if (obs_ctl !== 4'b0100) begin
      errors++;
      $display("FAIL bp_done: got %b expected 0100", obs_ctl);
    end
    @(negedge clk);
  endtask

  task automatic test_cfg_err();
    coord_ready = 1'b1;
    begin_scan(6, 9, 1'b0);
    checks++;
    if (obs_ctl !== 4'b1000) begin
      errors++;
      $display("FAIL cfg_load: got %b expected 1000", obs_ctl);
    end
    @(negedge clk);
    checks++;
    if (obs_ctl !== 4'b0110) begin
      errors++;
      $display("FAIL cfg_done: got %b expected 0110", obs_ctl);
    end
    @(negedge clk);
    checks++;
    if (obs_ctl !== 4'b0010) begin
      errors++;
      $display("FAIL cfg_sticky: got %b expected 0010", obs_ctl);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    coord_ready = 1'b1;
    begin_scan(10, 9, 1'b0);
    checks++;
    if (obs_ctl !== 4'b1000) begin
      errors++;
      $display("FAIL abort_load_cfgclr: got %b expected 1000", obs_ctl);
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs_coord !== exp_coord(i)) begin
        errors++;
        $display("FAIL abort_coord%0d: got %h expected %h", i, obs_coord, exp_coord(i));
      end
      if (i == 5) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    checks++;
    if (obs_ctl !== 4'b0000) begin
      errors++;
      $display("FAIL abort_stop: got %b expected 0000", obs_ctl);
    end
    @(negedge clk);
    checks++;
    if (obs_ctl !== 4'b0000) begin
      errors++;
      $display("FAIL abort_nodone: got %b expected 0000", obs_ctl);
    end
    begin_scan(10, 9, 1'b0);
    @(negedge clk);
    checks++;
    if (obs_coord !== exp_coord(0)) begin
      errors++;
      $display("FAIL abort_restart: got %h expected %h", obs_coord, exp_coord(0));
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midscan_and_start_busy();
    coord_ready = 1'b1;
    begin_scan(10, 9, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    checks++;
    if ({obs_ctl, obs_coord} !== 27'd0) begin
      errors++;
      $display("FAIL midscan_reset: got %h expected 0", {obs_ctl, obs_coord});
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    begin_scan(10, 9, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (obs_coord !== exp_coord(i)) begin
        errors++;
        $display("FAIL busy_start_coord%0d: got %h expected %h", i, obs_coord, exp_coord(i));
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (obs_ctl !== 4'b0100) begin
      errors++;
      $display("FAIL busy_start_done: got %b expected 0100", obs_ctl);
    end
    @(negedge clk);
    checks++;
    if (obs_ctl !== 4'b0000) begin
      errors++;
      $display("FAIL busy_start_idle: got %b expected 0000", obs_ctl);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 12; i++) begin
      exp_y[i] = 3 + i / 4;
`ifdef SERPENTINE_EN
      exp_x[i] = ((i / 4) % 2 == 1) ? (6 - i % 4) : (3 + i % 4);
`else
      exp_x[i] = 3 + i % 4;
`endif
    end
    test_reset();
    test_raster();
    test_backpressure();
    test_cfg_err();
    test_abort();
    test_reset_midscan_and_start_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
